pipelined_cla_addsub: RTL and testbench

- Parametrised, two-stage pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
- Each group produces a group propagate and a group generate; a second-level lookahead unit combines them into the inter-group carries.
- Adds subtract mode, status flags and a valid/ready handshake with backpressure.
- Sits between operand-sourcing logic and the datapath writeback stage, and replaces chained single-group adders for widths above 4.

---
 rtl/pipelined_cla_addsub.sv | 220 ++++++++++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub
//   Two-stage pipelined carry-lookahead adder/subtractor built from 4-bit
//   lookahead groups. Stage 1 forms per-bit propagate/generate and the
//   group propagate/generate terms. Stage 2 resolves the inter-group carries
//   with a flattened second-level lookahead, forms the sum and flags, and
//   registers everything. A valid/ready handshake supports backpressure.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   A, B       operands (WIDTH bits)
//   Ci         carry-in, add mode only
//   sub        0: A+B+Ci   1: A-B (A+~B+1, Ci ignored)
//   in_valid   operands valid this cycle
//   in_ready   stage 1 can accept
//   sum        result (WIDTH bits)
//   Co         carry-out of MSB (sub mode: 1 = no borrow)
//   ovf        signed overflow
//   zero       sum == 0
//   Pi, Gi     block propagate / generate for cascading
//   out_valid  result valid
//   out_ready  downstream accepts result

module pipelined_cla_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Co,
  output logic             ovf,
  output logic             zero,
  output logic             Pi,
  output logic             Gi,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NGRP = WIDTH / 4;

  generate
    if (WIDTH < 4 || WIDTH > 64 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("pipelined_cla_addsub: WIDTH must be a multiple of 4 in 4..64");
    end
  endgenerate

  // Flattened second-level lookahead: every group carry is a sum of
  // products over Pg/Gg and cin, so no carry ripples group to group.
  function automatic logic [NGRP:0] group_carries(
    input logic [NGRP-1:0] pg,
    input logic [NGRP-1:0] gg,
    input logic            cin
  );
    logic [NGRP:0] cg;
    logic          t;
    cg    = '0;
    cg[0] = cin;
    for (int k = 0; k < NGRP; k++) begin
      t = cin;
      for (int m = 0; m <= k; m++) t = t & pg[m];
      cg[k+1] = t;
      for (int j = 0; j <= k; j++) begin
        t = gg[j];
        for (int m = j + 1; m <= k; m++) t = t & pg[m];
        cg[k+1] = cg[k+1] | t;
      end
    end
    return cg;
  endfunction

  // Block generate: carry out of the whole block with zero carry-in.
  function automatic logic block_generate(
    input logic [NGRP-1:0] pg,
    input logic [NGRP-1:0] gg
  );
    logic g;
    logic t;
    g = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      t = gg[j];
      for (int m = j + 1; m < NGRP; m++) t = t & pg[m];
      g = g | t;
    end
    return g;
  endfunction

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic s1_valid;
  logic s2_adv;
  logic s1_adv;
  logic accept;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = s1_valid & s2_adv;
  assign in_ready = !s1_valid | s2_adv;
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------
  // Stage 1: propagate / generate
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic             c0_in;
  logic [NGRP-1:0]  pg_in;
  logic [NGRP-1:0]  gg_in;

  always_comb begin
    bx    = sub ? ~B : B;
    c0_in = sub ? 1'b1 : Ci;
    p_in  = A ^ bx;
    g_in  = A & bx;
    pg_in = '0;
    gg_in = '0;
    for (int k = 0; k < NGRP; k++) begin
      pg_in[k] = &p_in[4*k +: 4];
      gg_in[k] = g_in[4*k+3]
               | (p_in[4*k+3] & g_in[4*k+2])
               | (p_in[4*k+3] & p_in[4*k+2] & g_in[4*k+1])
               | (p_in[4*k+3] & p_in[4*k+2] & p_in[4*k+1] & g_in[4*k]);
    end
  end

  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic [NGRP-1:0]  s1_pg;
  logic [NGRP-1:0]  s1_gg;
  logic             s1_c0;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_pg    <= '0;
      s1_gg    <= '0;
      s1_c0    <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_p     <= p_in;
        s1_g     <= g_in;
        s1_pg    <= pg_in;
        s1_gg    <= gg_in;
        s1_c0    <= c0_in;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: carries, sum, flags
  // ---------------------------------------------------------------------
  logic [NGRP:0]    cg;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_nx;
  logic             co_nx;
  logic             ovf_nx;
  logic             zero_nx;
  logic             pi_nx;
  logic             gi_nx;

  always_comb begin
    cg = group_carries(s1_pg, s1_gg, s1_c0);
    c  = '0;
    // Intra-group carries: 4-bit lookahead seeded by the group carry.
    for (int k = 0; k < NGRP; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = s1_g[4*k] | (s1_p[4*k] & cg[k]);
      c[4*k+2] = s1_g[4*k+1]
               | (s1_p[4*k+1] & s1_g[4*k])
               | (s1_p[4*k+1] & s1_p[4*k] & cg[k]);
      c[4*k+3] = s1_g[4*k+2]
               | (s1_p[4*k+2] & s1_g[4*k+1])
               | (s1_p[4*k+2] & s1_p[4*k+1] & s1_g[4*k])
               | (s1_p[4*k+2] & s1_p[4*k+1] & s1_p[4*k] & cg[k]);
    end
    c[WIDTH] = cg[NGRP];
    sum_nx   = s1_p ^ c[WIDTH-1:0];
    co_nx    = c[WIDTH];
    ovf_nx   = c[WIDTH] ^ c[WIDTH-1];
    zero_nx  = ~|sum_nx;
    pi_nx    = &s1_pg;
    gi_nx    = block_generate(s1_pg, s1_gg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      Co        <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      Pi        <= 1'b0;
      Gi        <= 1'b0;
    end else begin
      if (s2_adv) out_valid <= s1_valid;
      // Result registers only change when a real op moves in, so they
      // stay stable under backpressure and read 0 until the first result.
      if (s1_adv) begin
        sum  <= sum_nx;
        Co   <= co_nx;
        ovf  <= ovf_nx;
        zero <= zero_nx;
        Pi   <= pi_nx;
        Gi   <= gi_nx;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        Ci;
  logic        sub;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sum;
  logic        Co;
  logic        ovf;
  logic        zero;
  logic        Pi;
  logic        Gi;
  logic        out_valid;
  logic        out_ready;

  int n_vec = 0;
  int n_err = 0;

  pipelined_cla_addsub #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Ci(Ci), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .Co(Co),
    .ovf(ovf), .zero(zero), .Pi(Pi), .Gi(Gi), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: plain wide addition, signed overflow from sign bits.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic sb, output logic [15:0] s, output logic co,
                       output logic v);
    logic [15:0] bb;
    logic [16:0] r;
    bb = sb ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {16'd0, (sb ? 1'b1 : ci)};
    s  = r[15:0];
    co = r[16];
    v  = (a[15] == bb[15]) && (s[15] != a[15]);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb, input logic [15:0] es,
                        input logic eco, input logic eovf, input logic ez,
                        input logic epi, input logic egi);
    A = a; B = b; Ci = ci; sub = sb; in_valid = 1'b1;
    chk({tag, "_rdy"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 1'b0);
    step();
    chk({tag, "_ov"}, out_valid, 1'b1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_co"}, Co, eco);
    chk({tag, "_ovf"}, ovf, eovf);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_pi"}, Pi, epi);
    chk({tag, "_gi"}, Gi, egi);
    step();
  endtask

  logic [15:0] ta [8];
  logic [15:0] tb [8];
  logic        tci [8];
  logic        tsb [8];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ms;
    logic        mco;
    logic        mv;
    int          rx;

    rst = 1'b1; A = '0; B = '0; Ci = 1'b0; sub = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    rst = 1'b0;

    chk("rst_ov", out_valid, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_flags", {Co, ovf, zero, Pi, Gi}, 5'b0);
    chk("rst_rdy", in_ready, 1'b1);

    // Directed vectors: a, b, ci, sub -> sum, Co, ovf, zero, Pi, Gi
    run_op("chain",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1, 0, 1, 0, 1);
    run_op("ovf_add",16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 0, 1, 0, 0, 0);
    run_op("ovf_sub",16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1, 1, 0, 0, 1);
    run_op("borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 0, 0, 0, 0, 0);
    run_op("cin",    16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 0, 0, 0, 0, 0);
    run_op("sub_ci0",16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3DCC, 1, 0, 0, 0, 1);
    run_op("sub_ci1",16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3DCC, 1, 0, 0, 0, 1);
    run_op("prop0",  16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 0, 0, 0, 1, 0);
    run_op("prop1",  16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1, 0, 1, 1, 0);

    // Back-to-back stream
    ta[0]=16'h0001; tb[0]=16'h0001; tci[0]=0; tsb[0]=0;
    ta[1]=16'hFFFF; tb[1]=16'hFFFF; tci[1]=1; tsb[1]=0;
    ta[2]=16'h8000; tb[2]=16'h8000; tci[2]=0; tsb[2]=0;
    ta[3]=16'h1234; tb[3]=16'h4321; tci[3]=0; tsb[3]=1;
    ta[4]=16'h0000; tb[4]=16'h0001; tci[4]=0; tsb[4]=1;
    ta[5]=16'h7FFF; tb[5]=16'h7FFF; tci[5]=1; tsb[5]=0;
    ta[6]=16'hABCD; tb[6]=16'h1111; tci[6]=1; tsb[6]=1;
    ta[7]=16'h00FF; tb[7]=16'hFF01; tci[7]=0; tsb[7]=0;
    rx = 0;
    for (int t = 0; t < 11; t++) begin
      if (t < 8) begin
        A = ta[t]; B = tb[t]; Ci = tci[t]; sub = tsb[t]; in_valid = 1'b1;
        chk("tp_rdy", in_ready, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      chk("tp_ov", out_valid, (t >= 1 && t <= 8));
      if (out_valid && rx < 8) begin
        model(ta[rx], tb[rx], tci[rx], tsb[rx], ms, mco, mv);
        chk("tp_sum", sum, ms);
        chk("tp_co", Co, mco);
        chk("tp_ovf", ovf, mv);
        rx++;
      end
    end
    chk("tp_cnt", rx, 8);

    // Backpressure: X = 0x0102+0x0304, Y = 0x1000-0x0001, Z never accepted
    out_ready = 1'b0;
    A = 16'h0102; B = 16'h0304; Ci = 0; sub = 0; in_valid = 1'b1;
    chk("bp_rdy0", in_ready, 1'b1);
    step();
    A = 16'h1000; B = 16'h0001; Ci = 0; sub = 1;
    chk("bp_rdy1", in_ready, 1'b1);
    step();
    A = 16'h5555; B = 16'h1111; Ci = 0; sub = 0;
    chk("bp_rdy2", in_ready, 1'b0);
    chk("bp_hold_ov", out_valid, 1'b1);
    chk("bp_hold_sum", sum, 16'h0406);
    step();
    chk("bp_rdy3", in_ready, 1'b0);
    chk("bp_hold_sum2", sum, 16'h0406);
    chk("bp_hold_co", Co, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_first", sum, 16'h0406);
    step();
    chk("bp_second_ov", out_valid, 1'b1);
    chk("bp_second", sum, 16'h0FFF);
    chk("bp_second_co", Co, 1'b1);
    step();
    chk("bp_drain", out_valid, 1'b0);

    // Reset with both stages full
    out_ready = 1'b0;
    A = 16'hFFFF; B = 16'h0001; Ci = 0; sub = 0; in_valid = 1'b1;
    step();
    A = 16'h0003; B = 16'h0004; Ci = 0; sub = 0;
    step();
    chk("mr_full", out_valid, 1'b1);
    chk("mr_full_zero", zero, 1'b1);
    A = 16'h0101; B = 16'h0101;
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("mr_ov", out_valid, 1'b0);
    chk("mr_sum", sum, 16'h0000);
    chk("mr_flags", {Co, ovf, zero, Pi, Gi}, 5'b0);
    chk("mr_rdy", in_ready, 1'b1);
    step();
    chk("mr_discard", out_valid, 1'b0);
    run_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
